// File: rtl/bt_uart_rx.sv
// bt_uart_rx
// ---------------------------------------------------------------------------
// Receives 8N1 frames from the Bluetooth module's TX line and hands each
// good byte to the display stage.
//
// The asynchronous line passes through a 2-FF synchroniser. A mid-bit
// sampling FSM then recovers each frame. Each good byte is held on `bt`
// until the next good byte arrives.
//
// Optional feature macro: BT_UART_PARITY_EN
//   When defined, a PARITY state is inserted between DATA and STOP. The
//   frame then carries one even-parity bit, and the `parity_err` port is
//   added.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   get_bluetooth asynchronous serial RX line, idle high
//   rd_ack        consumer acknowledges the held byte (single-cycle pulse)
//   bt            last good received byte
//   bt_valid      one-cycle pulse when `bt` is updated
//   bt_ready      high from a `bt` update until `rd_ack`
//   frame_err     one-cycle pulse when the stop bit is sampled low
//   parity_err    (BT_UART_PARITY_EN only) one-cycle pulse on parity
//                 mismatch with a good stop bit
//   overrun       sticky: a byte completed while `bt_ready` was still high
//
// Handshake
//   `bt_valid` is a one-cycle strobe. It is not back-pressured.
//   `bt_ready` goes high on every load and drops the cycle after `rd_ack`.
//   If a load and `rd_ack` occur in the same cycle, the load wins:
//   `bt_ready` stays high and no overrun is recorded.
//
// Debug visibility
//   The FSM state is held in the `state` register (type state_t).
//
// ---------------------------------------------------------------------------
module bt_uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       get_bluetooth,
  input  logic       rd_ack,
  output logic [7:0] bt,
  output logic       bt_valid,
  output logic       bt_ready,
  output logic       frame_err,
`ifdef BT_UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef BT_UART_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          rx_meta, rx_s;
  logic          load, ferr;
`ifdef BT_UART_PARITY_EN
  logic          par_bit, par_n;
  logic          perr;
`endif

  // The synchroniser resets to the idle level. This prevents a reset from
  // looking like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= get_bluetooth;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef BT_UART_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
`ifdef BT_UART_PARITY_EN
      par_bit <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    load    = 1'b0;
    ferr    = 1'b0;
`ifdef BT_UART_PARITY_EN
    par_n   = par_bit;
    perr    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Re-check the line at the middle of the start bit. A short low
        // glitch is dropped silently.
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};  // LSB arrives first
          if (bit_cnt == 3'd7) begin
            bit_n = '0;
`ifdef BT_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef BT_UART_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef BT_UART_PARITY_EN
            // Even parity: the data bits plus the parity bit XOR to zero.
            if ((^shift) == par_bit) load = 1'b1;
            else                     perr = 1'b1;
`else
            load = 1'b1;
`endif
          end else begin
            ferr    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A break or stuck-low line must not be seen as a new start bit.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bt         <= 8'h00;
      bt_valid   <= 1'b0;
      bt_ready   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef BT_UART_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      bt_valid  <= load;
      frame_err <= ferr;
`ifdef BT_UART_PARITY_EN
      parity_err <= perr;
`endif
      if (load) bt <= shift;
      if (load)        bt_ready <= 1'b1;
      else if (rd_ack) bt_ready <= 1'b0;
      // An acknowledge in the load cycle means the old byte was consumed.
      if (load && bt_ready && !rd_ack) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bt_uart_rx.sv
// tb_bt_uart_rx
// Self-checking bench for bt_uart_rx with CLKS_PER_BIT=16 and a 2 ns clock.
// A bit-level line driver sends the frames. A negedge monitor collects the
// received bytes and the error pulses. Each scenario task compares these
// against values derived from the frame rules.
module tb_bt_uart_rx;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef BT_UART_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int FRAME_CYC = (10 + NPAR) * CPB;
  localparam int EXP_LAT   = 2 + HALF + 9 * CPB + 1 + NPAR * CPB;

  logic       clk;
  logic       rst;
  logic       get_bluetooth;
  logic       rd_ack;
  logic [7:0] bt;
  logic       bt_valid;
  logic       bt_ready;
  logic       frame_err;
  logic       overrun;
`ifdef BT_UART_PARITY_EN
  logic       parity_err;
  logic       par_flip;
  int         n_perr = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int last_valid_edge = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  bt_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .get_bluetooth(get_bluetooth),
    .rd_ack       (rd_ack),
    .bt           (bt),
    .bt_valid     (bt_valid),
    .bt_ready     (bt_ready),
    .frame_err    (frame_err),
`ifdef BT_UART_PARITY_EN
    .parity_err   (parity_err),
`endif
    .overrun      (overrun)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #1 clk = ~clk;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  // Monitor
  always @(negedge clk) begin
    if (bt_valid === 1'b1) begin
      got_q.push_back(bt);
      n_valid = n_valid + 1;
      last_valid_edge = edge_cnt;
    end
    if (frame_err === 1'b1) n_ferr = n_ferr + 1;
`ifdef BT_UART_PARITY_EN
    if (parity_err === 1'b1) n_perr = n_perr + 1;
`endif
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #0.1;
    end
  endtask

  // The line is left at the stop level. The caller releases a low stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    get_bluetooth = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      get_bluetooth = d[i];
      tick(CPB);
    end
`ifdef BT_UART_PARITY_EN
    get_bluetooth = (^d) ^ par_flip;
    tick(CPB);
`endif
    get_bluetooth = stop_b;
    tick(CPB);
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
    tick(2);
  endtask

  // Scenarios
  task automatic test_reset();
    int v0, f0;
    get_bluetooth = 1'b1;
    rd_ack = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    n_checks++;
    if (bt !== 8'h00) $display("FAIL reset_bt: got %h expected 00", bt);
    else n_pass++;
    n_checks++;
    if ({bt_valid, bt_ready, frame_err, overrun} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000",
               {bt_valid, bt_ready, frame_err, overrun});
    else n_pass++;
    v0 = n_valid;
    f0 = n_ferr;
    tick(500);
    n_checks++;
    if ((n_valid - v0) + (n_ferr - f0) !== 0)
      $display("FAIL reset_quiet: got %0d pulses expected 0", (n_valid - v0) + (n_ferr - f0));
    else n_pass++;
  endtask

  task automatic test_single_byte();
    int v0, s, lat;
    v0 = n_valid;
    s = edge_cnt;
    send_frame(8'hA5, 1'b1);
    tick(4);
    n_checks++;
    if (n_valid - v0 !== 1) $display("FAIL single_pulses: got %0d expected 1", n_valid - v0);
    else n_pass++;
    n_checks++;
    if (bt !== 8'hA5) $display("FAIL single_bt: got %h expected a5", bt);
    else n_pass++;
    lat = last_valid_edge - s;
    n_checks++;
    if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1)
      $display("FAIL single_latency: got %0d expected %0d+-1", lat, EXP_LAT);
    else n_pass++;
    n_checks++;
    if (bt_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", bt_ready);
    else n_pass++;
    ack_pulse();
    n_checks++;
    if (bt_ready !== 1'b0) $display("FAIL ack_clears: got %b expected 0", bt_ready);
    else n_pass++;
    ack_pulse();
    n_checks++;
    if ({bt_ready, bt} !== {1'b0, 8'hA5})
      $display("FAIL idle_ack: got %b/%h expected 0/a5", bt_ready, bt);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    get_bluetooth = 1'b0;
    tick(4);
    get_bluetooth = 1'b1;
    tick(40);
    n_checks++;
    if ((n_valid - v0) + (n_ferr - f0) !== 0 || bt !== 8'hA5)
      $display("FAIL glitch: got %0d pulses bt %h expected 0 pulses bt a5",
               (n_valid - v0) + (n_ferr - f0), bt);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    tick(40);
    n_checks++;
    if (n_ferr - f0 !== 1) $display("FAIL ferr_pulse: got %0d expected 1", n_ferr - f0);
    else n_pass++;
    n_checks++;
    if ({n_valid - v0, bt_ready, bt} !== {32'd0, 1'b0, 8'hA5})
      $display("FAIL ferr_hold: got valid %0d ready %b bt %h expected 0 0 a5",
               n_valid - v0, bt_ready, bt);
    else n_pass++;
    get_bluetooth = 1'b1;
    tick(20);
    n_checks++;
    if (n_ferr - f0 !== 1) $display("FAIL ferr_retrigger: got %0d expected 1", n_ferr - f0);
    else n_pass++;
    send_frame(8'hC3, 1'b1);
    tick(4);
    n_checks++;
    if ({n_valid - v0, bt} !== {32'd1, 8'hC3})
      $display("FAIL ferr_recover: got %0d/%h expected 1/c3", n_valid - v0, bt);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset(1);
    got_q.delete();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    n_checks++;
    if ({overrun, bt} !== {1'b1, 8'h22})
      $display("FAIL overrun_set: got %b/%h expected 1/22", overrun, bt);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22)
      $display("FAIL overrun_seq: got %0d bytes expected 11,22", got_q.size());
    else n_pass++;
    ack_pulse();
    tick(3);
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun);
    else n_pass++;
  endtask

  task automatic test_simul_ack();
    int s, tgt;
    do_reset(1);
    s = edge_cnt;
    tgt = s + FRAME_CYC + EXP_LAT - 1;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        while (edge_cnt < tgt) tick(1);
        ack_pulse();
      end
    join
    tick(4);
    n_checks++;
    if ({overrun, bt_ready, bt} !== {1'b0, 1'b1, 8'h22})
      $display("FAIL simul_ack: got ovr %b ready %b bt %h expected 0 1 22",
               overrun, bt_ready, bt);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int v0;
    do_reset(1);
    got_q.delete();
    v0 = n_valid;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(CPB * 5 + HALF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    join
    tick(4);
    send_frame(8'h5A, 1'b1);
    tick(4);
    n_checks++;
    if (n_valid - v0 !== 1 || got_q.size() != 1)
      $display("FAIL midreset_count: got %0d expected 1", n_valid - v0);
    else n_pass++;
    n_checks++;
    if (bt !== 8'h5A || (got_q.size() > 0 && got_q[0] !== 8'h5A))
      $display("FAIL midreset_bt: got %h expected 5a", bt);
    else n_pass++;
  endtask

  task automatic test_random();
    int f0, exp_ferr;
    logic [7:0] d;
    logic bad, mdl_ready, mdl_ovr;
    do_reset(1);
    got_q.delete();
    exp_q.delete();
    f0 = n_ferr;
    exp_ferr = 0;
    mdl_ready = 1'b0;
    mdl_ovr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      send_frame(d, !bad);
      if (bad) begin
        tick($urandom_range(1, 30));
        get_bluetooth = 1'b1;
        tick(CPB);
        exp_ferr++;
      end else begin
        exp_q.push_back(d);
        if (mdl_ready) mdl_ovr = 1'b1;
        mdl_ready = 1'b1;
      end
      tick($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        mdl_ready = 1'b0;
      end
    end
    tick(4);
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (n_ferr - f0 !== exp_ferr)
      $display("FAIL rand_ferr: got %0d expected %0d", n_ferr - f0, exp_ferr);
    else n_pass++;
    n_checks++;
    if ({bt_ready, overrun} !== {mdl_ready, mdl_ovr})
      $display("FAIL rand_flags: got %b%b expected %b%b", bt_ready, overrun, mdl_ready, mdl_ovr);
    else n_pass++;
    if (exp_q.size() > 0) begin
      n_checks++;
      if (bt !== exp_q[exp_q.size() - 1])
        $display("FAIL rand_last: got %h expected %h", bt, exp_q[exp_q.size() - 1]);
      else n_pass++;
    end
  endtask

`ifdef BT_UART_PARITY_EN
  task automatic test_parity();
    int v0, p0;
    do_reset(1);
    v0 = n_valid;
    p0 = n_perr;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    tick(4);
    n_checks++;
    if ({n_valid - v0, n_perr - p0, bt} !== {32'd1, 32'd0, 8'h07})
      $display("FAIL parity_good: got %0d/%0d/%h expected 1/0/07", n_valid - v0, n_perr - p0, bt);
    else n_pass++;
    ack_pulse();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tick(4);
    par_flip = 1'b0;
    n_checks++;
    if ({n_valid - v0, n_perr - p0, bt, bt_ready} !== {32'd1, 32'd1, 8'h07, 1'b0})
      $display("FAIL parity_bad: got %0d/%0d/%h/%b expected 1/1/07/0",
               n_valid - v0, n_perr - p0, bt, bt_ready);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    get_bluetooth = 1'b1;
    rd_ack = 1'b0;
`ifdef BT_UART_PARITY_EN
    par_flip = 1'b0;
`endif
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_simul_ack();
    test_reset_midframe();
    test_random();
`ifdef BT_UART_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bt_uart_rx.md
Name: bt_uart_rx

Overview:
- Serial receiver for the Bluetooth module's TX line; sits directly upstream of the screen/display stage.
- Synchronises the asynchronous `get_bluetooth` line and recovers 8N1 frames by mid-bit sampling.
- Presents each received byte on `bt` with a one-cycle valid strobe, an unread flag and error flags for the display logic.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit period (100 MHz / 9600 baud); legal range 4..65535.
- HALF_BIT, CLKS_PER_BIT/2 (integer floor), cycles from start-edge detection to the start-bit mid-point sample.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- get_bluetooth  in  1  asynchronous serial RX line; idle high
- rd_ack  in  1  consumer acknowledges the held byte (single-cycle pulse)
- bt  out  8  last good received byte, held until the next good byte
- bt_valid  out  1  one-cycle pulse when `bt` is updated
- bt_ready  out  1  high from a `bt` update until `rd_ack`
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- overrun  out  1  sticky; a new byte completed while `bt_ready` was high

Behaviour:
- Reset (rst=1 at a clk edge):
  - State returns to IDLE; bit and cycle counters clear.
  - Synchroniser flops load 1.
  - Outputs: bt=8'h00, bt_valid=0, bt_ready=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame with no output pulse.
- Input path: 2-FF synchroniser gives `rx_s`; the FSM uses only `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: `rx_s`=0 → START, cycle counter cleared.
- START: count HALF_BIT cycles, then sample `rx_s`.
  - Sample 0 → DATA.
  - Sample 1 → IDLE (glitch rejected, no flag).
- DATA: every CLKS_PER_BIT cycles, sample `rx_s` into a shift register, LSB first.
  - After the 8th sample → STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
  - Sample 1: next cycle bt ← shift register, bt_valid=1 for one cycle, bt_ready=1; state → IDLE.
  - Sample 0: next cycle frame_err=1 for one cycle; bt and bt_ready unchanged; state → WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then → IDLE. This stops a stuck-low line or a break from re-triggering.
- Latency: bt_valid asserts exactly 2 + HALF_BIT + 9×CLKS_PER_BIT + 1 cycles after the pin's start-bit falling edge. The bench allows ±1 for edge phase.
- Handshake:
  - `rd_ack` clears bt_ready on the next cycle.
  - `rd_ack` while bt_ready=0 is ignored.
  - `rd_ack` in the same cycle as a new byte load: the load wins, bt_ready stays 1 and overrun is not set.
- Overrun: a byte load while bt_ready=1 and no rd_ack that cycle sets overrun=1.
  - The new byte still overwrites `bt`.
  - overrun clears only on rst.
- Counters: cycle counter width is clog2(CLKS_PER_BIT); the bit counter is 3 bits. Neither wraps outside its state.
- Back-to-back frames: a start bit arriving immediately after a good stop mid-point is accepted. No idle time between frames is required.

Optional Feature:
- Macro: BT_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It samples one extra bit after CLKS_PER_BIT cycles, with even parity across the 8 data bits plus the parity bit.
  - Extra output port `parity_err` (1 bit, reset 0) pulses for one cycle when parity mismatches and the stop bit is good. In that case `bt` is not updated, bt_valid stays 0, and the state goes to IDLE.
  - Latency grows by CLKS_PER_BIT.
- Undefined:
  - 8N1 only; no PARITY state.
  - The `parity_err` port does not exist.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8, clk period 2 ns):
- Reset: hold rst for 3 cycles with the line idle-high → all outputs 0 and bt=8'h00; no pulse for 500 cycles afterwards.
- Single byte: send 8'hA5 as 8N1 → bt=8'hA5, one bt_valid pulse 155±1 cycles after the start edge, bt_ready=1. Pulse rd_ack → bt_ready=0 next cycle.
- Glitch and frame error:
  - 4-cycle low pulse on the idle line → no outputs.
  - Frame 8'h3C with stop bit low, line held low 40 more cycles → one frame_err pulse; bt unchanged; no new frame until the line returns high.
- Overrun and simultaneous ack:
  - Send 8'h11 then 8'h22 back-to-back without rd_ack → overrun=1, bt=8'h22.
  - After rst, repeat with rd_ack asserted in the same cycle as the second load → overrun stays 0, bt_ready=1.
- Reset mid-frame: assert rst during data bit 4 of 8'hFF, then send 8'h5A → only 8'h5A is reported, with exactly one bt_valid pulse.
- Parity (BT_UART_PARITY_EN defined):
  - 8'h07 with parity bit 1 → accepted.
  - 8'h07 with parity bit 0 → one parity_err pulse, bt unchanged.
